// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result bundle between a requester and serial_adder
interface serial_adder_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder feeding one full-adder cell per clock, LSB first
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic result,
    output logic cout
);
    assign result = a ^ b ^ cin;
    assign cout   = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(parameter int WIDTH = 8) (
    input  logic          clk,
    input  logic          reset,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    logic [1:0]       state;
    logic [WIDTH-1:0] sa, sb, sum, sum_nxt;
    logic [CW-1:0]    cnt;
    logic             carry, cout, fa_r, fa_c;
    full_adder u_fa (.a(sa[0]), .b(sb[0]), .cin(carry), .result(fa_r), .cout(fa_c));
    // new bit enters at the top so the first-computed bit lands in bit 0
    generate
        if (WIDTH == 1) begin : g_one
            assign sum_nxt = fa_r;
        end else begin : g_wide
            assign sum_nxt = {fa_r, sum[WIDTH-1:1]};
        end
    endgenerate
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                sa    <= bus.a;
                sb    <= bus.b;
                carry <= bus.cin;
                cnt   <= '0;
                sum   <= '0;
                state <= RUN;
            end
        end else if (state == RUN) begin
            sum   <= sum_nxt;
            carry <= fa_c;
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            cnt   <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
                state <= DONE;
                cout  <= fa_c;
            end
        end else begin
            state <= IDLE;
        end
    end
    assign bus.busy = state == RUN;
    assign bus.done = state == DONE;
    assign bus.sum  = sum;
    assign bus.cout = cout;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder at WIDTH 8, 1 and 16
module tb_serial_adder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    logic [8:0]  q8[$];
    logic [1:0]  q1[$];
    logic [16:0] q16[$];
    serial_adder_if #(.WIDTH(8))  i8 ();
    serial_adder_if #(.WIDTH(1))  i1 ();
    serial_adder_if #(.WIDTH(16)) i16 ();
    serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(i8));
    serial_adder #(.WIDTH(1))  dut1  (.clk(clk), .reset(reset), .bus(i1));
    serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(i16));
    always #5 clk = ~clk;

    // leaves the caller at the falling edge right after the accepting edge
    task automatic go8(input logic [7:0] x, input logic [7:0] y, input logic c);
        @(negedge clk);
        i8.start = 1'b1; i8.a = x; i8.b = y; i8.cin = c;
        q8.push_back({1'b0, x} + {1'b0, y} + 9'(c));
        @(negedge clk);
        i8.start = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        vectors++;
        if ({i8.busy, i8.done, i8.cout, i8.sum} !== 11'b0) begin
            miscompares++;
            $display("FAIL reset8: busy=%b done=%b sum=%h cout=%b, want all 0", i8.busy, i8.done, i8.sum, i8.cout);
        end
        vectors++;
        if ({i1.busy, i1.done, i1.cout, i1.sum} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset1: busy=%b done=%b sum=%h cout=%b, want all 0", i1.busy, i1.done, i1.sum, i1.cout);
        end
        vectors++;
        if ({i16.busy, i16.done, i16.cout, i16.sum} !== 19'b0) begin
            miscompares++;
            $display("FAIL reset16: busy=%b done=%b sum=%h cout=%b, want all 0", i16.busy, i16.done, i16.sum, i16.cout);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic;
        logic [8:0] exp;
        go8(8'h5A, 8'h3C, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            vectors++;
            if (i8.busy !== 1'b1 || i8.done !== 1'b0) begin
                miscompares++;
                $display("FAIL basic_busy cycle %0d: busy=%b done=%b, want busy=1 done=0", k, i8.busy, i8.done);
            end
            @(negedge clk);
        end
        exp = q8.pop_front();
        vectors++;
        if (i8.done !== 1'b1 || i8.busy !== 1'b0 || {i8.cout, i8.sum} !== exp) begin
            miscompares++;
            $display("FAIL basic_done: done=%b busy=%b cout/sum=%h, want done=1 busy=0 cout/sum=%h", i8.done, i8.busy, {i8.cout, i8.sum}, exp);
        end
        @(negedge clk);
        vectors++;
        if (i8.done !== 1'b0 || {i8.cout, i8.sum} !== exp) begin
            miscompares++;
            $display("FAIL basic_after: done=%b cout/sum=%h, want done=0 cout/sum=%h", i8.done, {i8.cout, i8.sum}, exp);
        end
    endtask

    task automatic test_ignored_start;
        int dones = 0;
        logic [8:0] exp;
        go8(8'h01, 8'h02, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            if (k == 3) begin
                i8.start = 1'b1; i8.a = 8'hF0; i8.b = 8'h0F;
            end
            if (k == 4) i8.start = 1'b0;
            if (i8.done === 1'b1) begin
                dones++;
                exp = q8.size() != 0 ? q8.pop_front() : 9'h1FF;
                vectors++;
                if ({i8.cout, i8.sum} !== exp || k != 9) begin
                    miscompares++;
                    $display("FAIL ignored_result: cycle %0d cout/sum=%h, want cycle 9 cout/sum=%h", k, {i8.cout, i8.sum}, exp);
                end
            end
            @(negedge clk);
        end
        vectors++;
        if (dones != 1) begin
            miscompares++;
            $display("FAIL ignored_dones: %0d done pulses, want 1", dones);
        end
        go8(8'h11, 8'h22, 1'b1);
        repeat (8) @(negedge clk);
        exp = q8.pop_front();
        vectors++;
        if (i8.done !== 1'b1 || {i8.cout, i8.sum} !== exp) begin
            miscompares++;
            $display("FAIL held_done: done=%b cout/sum=%h, want done=1 cout/sum=%h", i8.done, {i8.cout, i8.sum}, exp);
        end
        i8.start = 1'b1; i8.a = 8'h40; i8.b = 8'h04; i8.cin = 1'b0;
        @(negedge clk);
        vectors++;
        if (i8.busy !== 1'b0 || i8.done !== 1'b0 || i8.sum !== exp[7:0]) begin
            miscompares++;
            $display("FAIL held_idle: busy=%b done=%b sum=%h, want busy=0 done=0 sum=%h", i8.busy, i8.done, i8.sum, exp[7:0]);
        end
        q8.push_back(9'h044);
        @(negedge clk);
        i8.start = 1'b0;
        vectors++;
        if (i8.busy !== 1'b1 || i8.sum !== 8'h00) begin
            miscompares++;
            $display("FAIL restart_clear: busy=%b sum=%h, want busy=1 sum=00", i8.busy, i8.sum);
        end
        repeat (8) @(negedge clk);
        exp = q8.pop_front();
        vectors++;
        if (i8.done !== 1'b1 || {i8.cout, i8.sum} !== exp) begin
            miscompares++;
            $display("FAIL restart_result: done=%b cout/sum=%h, want done=1 cout/sum=%h", i8.done, {i8.cout, i8.sum}, exp);
        end
    endtask

    task automatic test_carry;
        logic [16:0] tv [4];
        logic [8:0] exp;
        int k;
        logic ok;
        tv = '{{8'h00, 8'h00, 1'b0}, {8'h80, 8'h80, 1'b0}, {8'hFF, 8'h01, 1'b0}, {8'hFF, 8'hFF, 1'b1}};
        foreach (tv[n]) begin
            go8(tv[n][16:9], tv[n][8:1], tv[n][0]);
            k = 1;
            ok = 1'b1;
            while (i8.done !== 1'b1 && k < 20) begin
                if (i8.busy !== 1'b1) ok = 1'b0;
                @(negedge clk);
                k++;
            end
            exp = q8.pop_front();
            vectors++;
            if (!ok || k != 9 || i8.busy !== 1'b0 || {i8.cout, i8.sum} !== exp) begin
                miscompares++;
                $display("FAIL carry%0d: done at cycle %0d busy_ok=%b cout/sum=%h, want cycle 9 busy_ok=1 cout/sum=%h", n, k, ok, {i8.cout, i8.sum}, exp);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [8:0] exp;
        logic seen = 1'b0;
        go8(8'hAA, 8'h55, 1'b0);
        q8.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if ({i8.busy, i8.done, i8.cout, i8.sum} !== 11'b0) begin
            miscompares++;
            $display("FAIL reset_mid: busy=%b done=%b sum=%h cout=%b, want all 0", i8.busy, i8.done, i8.sum, i8.cout);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (i8.done !== 1'b0 || i8.busy !== 1'b0) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL reset_quiet: busy/done activity=%b after reset, want 0", seen);
        end
        go8(8'hC3, 8'h3D, 1'b1);
        repeat (8) @(negedge clk);
        exp = q8.pop_front();
        vectors++;
        if (i8.done !== 1'b1 || {i8.cout, i8.sum} !== exp) begin
            miscompares++;
            $display("FAIL reset_recover: done=%b cout/sum=%h, want done=1 cout/sum=%h", i8.done, {i8.cout, i8.sum}, exp);
        end
    endtask

    task automatic test_width1;
        logic [1:0] exp;
        for (int v = 7; v >= 0; v--) begin
            @(negedge clk);
            i1.start = 1'b1; i1.a = v[2]; i1.b = v[1]; i1.cin = v[0];
            q1.push_back(2'(v[2]) + 2'(v[1]) + 2'(v[0]));
            @(negedge clk);
            i1.start = 1'b0;
            vectors++;
            if (i1.busy !== 1'b1 || i1.done !== 1'b0) begin
                miscompares++;
                $display("FAIL w1_busy v%0d: busy=%b done=%b, want busy=1 done=0", v, i1.busy, i1.done);
            end
            @(negedge clk);
            exp = q1.pop_front();
            vectors++;
            if (i1.done !== 1'b1 || i1.busy !== 1'b0 || {i1.cout, i1.sum} !== exp) begin
                miscompares++;
                $display("FAIL w1_done v%0d: done=%b busy=%b cout/sum=%b, want done=1 busy=0 cout/sum=%b", v, i1.done, i1.busy, {i1.cout, i1.sum}, exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] x, y;
        logic c, ok;
        logic [16:0] exp;
        int k;
        for (int n = 0; n < 1000; n++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            c = 1'($urandom);
            @(negedge clk);
            i16.start = 1'b1; i16.a = x; i16.b = y; i16.cin = c;
            q16.push_back({1'b0, x} + {1'b0, y} + 17'(c));
            @(negedge clk);
            i16.start = 1'b0;
            i16.a = ~x;
            k = 1;
            ok = 1'b1;
            while (i16.done !== 1'b1 && k < 30) begin
                if (i16.busy !== 1'b1) ok = 1'b0;
                @(negedge clk);
                k++;
            end
            vectors++;
            if (!ok || k != 17 || i16.busy !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_timing %0d: done at cycle %0d busy_ok=%b, want cycle 17 busy_ok=1", n, k, ok);
            end
            exp = q16.pop_front();
            vectors++;
            if ({i16.cout, i16.sum} !== exp) begin
                miscompares++;
                $display("FAIL b2b_result %0d: cout/sum=%h, want %h (a=%h b=%h cin=%b)", n, {i16.cout, i16.sum}, exp, x, y, c);
            end
        end
    endtask

    initial begin
        i8.start = 1'b0;  i8.a = '0;  i8.b = '0;  i8.cin = 1'b0;
        i1.start = 1'b0;  i1.a = '0;  i1.b = '0;  i1.cin = 1'b0;
        i16.start = 1'b0; i16.a = '0; i16.b = '0; i16.cin = 1'b0;
        test_reset;
        test_basic;
        test_ignored_start;
        test_carry;
        test_reset_mid;
        test_width1;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
